usr_sequencer: RTL and testbench

Command-driven sequencer that sits directly upstream of the 4-bit universal shift register and drives its mode, serial-fill and parallel-load inputs. It accepts one command at a time over a valid/ready handshake: load, logical shift, arithmetic shift right, or rotate, by 0–7 positions. It then issues one register operation per clock and pulses `done` when the command completes. The register's current contents are fed back so the block can produce rotate and sign-fill bits.

---
 rtl/usr_sequencer.sv | 146 ++++++++++++++
 tb/tb_usr_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usr_sequencer.sv
// Command sequencer for the 4-bit universal shift register.
// Accepts one command over valid/ready, then drives one register
// operation per clock (mode / serial fill / parallel load) and pulses
// done when the command has completed.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a command, mode held at 0, cmd_ready high
// RUN     | one register operation per cycle while rem counts down
// DONE    | one-cycle done pulse, then back to IDLE
module usr_sequencer (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [2:0] cmd_op,
   input  logic [3:0] cmd_data,
   input  logic [2:0] cmd_count,
   input  logic       cmd_fill,
   input  logic [3:0] reg_q,
   output logic [1:0] mode,
   output logic       shift_L,
   output logic       shift_R,
   output logic [3:0] parallel_in,
   output logic       busy,
   output logic       done
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [2:0] OP_LOAD = 3'd0;
   localparam logic [2:0] OP_SHL  = 3'd1;
   localparam logic [2:0] OP_SHR  = 3'd2;
   localparam logic [2:0] OP_ROL  = 3'd3;
   localparam logic [2:0] OP_ROR  = 3'd4;
   localparam logic [2:0] OP_ASR  = 3'd5;

   localparam logic [1:0] MODE_HOLD  = 2'd0;
   localparam logic [1:0] MODE_LEFT  = 2'd1;
   localparam logic [1:0] MODE_RIGHT = 2'd2;
   localparam logic [1:0] MODE_LOAD  = 2'd3;

   logic [1:0] state;
   logic [2:0] rem;
   logic [2:0] op_q;
   logic       fill_q;
   logic       accept;
   logic [2:0] rem_init;
   logic [1:0] mode_init;

   assign cmd_ready = (state == ST_IDLE) && !rst;
   assign accept    = cmd_valid && cmd_ready;
   assign busy      = (state == ST_RUN) || (state == ST_DONE);
   assign done      = (state == ST_DONE);

   // Step count and register mode implied by the incoming command;
   // reserved ops get zero steps so they complete without touching the register.
   always_comb begin
      rem_init  = 3'd0;
      mode_init = MODE_HOLD;
      case (cmd_op)
         OP_LOAD: begin
            rem_init  = 3'd1;
            mode_init = MODE_LOAD;
         end
         OP_SHL, OP_ROL: begin
            rem_init  = cmd_count;
            mode_init = MODE_LEFT;
         end
         OP_SHR, OP_ROR, OP_ASR: begin
            rem_init  = cmd_count;
            mode_init = MODE_RIGHT;
         end
         default: begin
            rem_init  = 3'd0;
            mode_init = MODE_HOLD;
         end
      endcase
   end

   // Sequencer state, step counter, captured command and registered mode.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         rem         <= 3'd0;
         mode        <= MODE_HOLD;
         op_q        <= OP_LOAD;
         fill_q      <= 1'b0;
         parallel_in <= 4'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  op_q        <= cmd_op;
                  fill_q      <= cmd_fill;
                  parallel_in <= cmd_data;
                  rem         <= rem_init;
                  if (rem_init != 3'd0) begin
                     state <= ST_RUN;
                     mode  <= mode_init;
                  end else begin
                     state <= ST_DONE;
                     mode  <= MODE_HOLD;
                  end
               end
            end
            ST_RUN: begin
               rem <= rem - 3'd1;
               if (rem <= 3'd1) begin
                  state <= ST_DONE;
                  mode  <= MODE_HOLD;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               mode  <= MODE_HOLD;
            end
            default: begin
               state <= ST_IDLE;
               mode  <= MODE_HOLD;
            end
         endcase
      end
   end

   // Serial insert bits: fill for logical shifts, wrapped bit for rotates,
   // sign bit for ASR; zero for ops that do not shift in a bit.
   always_comb begin
      shift_L = 1'b0;
      shift_R = 1'b0;
      case (op_q)
         OP_SHL:  shift_L = fill_q;
         OP_SHR:  shift_R = fill_q;
         OP_ROL:  shift_L = reg_q[3];
         OP_ROR:  shift_R = reg_q[0];
         OP_ASR:  shift_R = reg_q[3];
         default: begin
            shift_L = 1'b0;
            shift_R = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_usr_sequencer.sv
// Bench for usr_sequencer: a falling-edge shift register model closes the
// loop, a directed table plus hand sequences cover the listed scenarios,
// and random commands are checked against an arithmetic result model.
module tb_usr_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [3:0] cmd_data;
   logic [2:0] cmd_count;
   logic       cmd_fill;
   logic [3:0] reg_q = 4'd0;
   logic [1:0] mode;
   logic       shift_L;
   logic       shift_R;
   logic [3:0] parallel_in;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

   usr_sequencer dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count),
      .cmd_fill(cmd_fill), .reg_q(reg_q), .mode(mode), .shift_L(shift_L),
      .shift_R(shift_R), .parallel_in(parallel_in), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Downstream 4-bit universal shift register, updating on the falling edge.
   always @(negedge clk) begin
      case (mode)
         2'd1: reg_q <= {reg_q[2:0], shift_L};
         2'd2: reg_q <= {shift_R, reg_q[3:1]};
         2'd3: reg_q <= parallel_in;
         default: reg_q <= reg_q;
      endcase
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int exp_rem(input logic [2:0] op, input logic [2:0] count);
      if (op == 3'd0) return 1;
      if (op <= 3'd5) return int'(count);
      return 0;
   endfunction

   function automatic int exp_mode(input logic [2:0] op);
      case (op)
         3'd0: return 3;
         3'd1, 3'd3: return 1;
         3'd2, 3'd4, 3'd5: return 2;
         default: return 0;
      endcase
   endfunction

   function automatic int exp_sl(input logic [2:0] op, input logic fill, input logic [3:0] q);
      if (op == 3'd1) return int'(fill);
      if (op == 3'd3) return int'(q[3]);
      return 0;
   endfunction

   function automatic int exp_sr(input logic [2:0] op, input logic fill, input logic [3:0] q);
      if (op == 3'd2) return int'(fill);
      if (op == 3'd4) return int'(q[0]);
      if (op == 3'd5) return int'(q[3]);
      return 0;
   endfunction

   // Final register value from the command's arithmetic meaning.
   function automatic logic [3:0] ref_q(input logic [3:0] q, input logic [2:0] op,
                                        input logic [3:0] data, input int n, input logic fill);
      int v;
      int r;
      int s;
      v = int'(q);
      r = n % 4;
      case (op)
         3'd0: return data;
         3'd1: begin
            if (n >= 4) return {4{fill}};
            return 4'(((v << n) | (fill ? ((1 << n) - 1) : 0)) & 15);
         end
         3'd2: begin
            if (n >= 4) return {4{fill}};
            return 4'((v >> n) | (fill ? (15 - ((1 << (4 - n)) - 1)) : 0));
         end
         3'd3: return 4'(((v << r) | (v >> (4 - r))) & 15);
         3'd4: return 4'(((v >> r) | (v << (4 - r))) & 15);
         3'd5: begin
            s = q[3] ? v - 16 : v;
            return 4'((s >>> n) & 15);
         end
         default: return q;
      endcase
   endfunction

   // Issue one command from a sample point and check it through to cmd_ready.
   task automatic run_cmd(input logic [2:0] op, input logic [3:0] data, input logic [2:0] count,
                          input logic fill, input logic [3:0] exp_q, input int exp_lat);
      int waitc;
      int lat;
      int mcnt;
      int rem_e;
      rem_e = exp_rem(op, count);
      waitc = 0;
      while (!cmd_ready && waitc < 50) begin
         @(posedge clk); #1;
         waitc++;
      end
      chk("ready_wait", int'(cmd_ready), 1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      cmd_count = count;
      cmd_fill  = fill;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      lat  = 1;
      mcnt = 0;
      while (!done && lat < 20) begin
         chk("run_mode", int'(mode), (lat <= rem_e) ? exp_mode(op) : 0);
         if (mode != 2'd0) mcnt++;
         chk("run_shift_L", int'(shift_L), exp_sl(op, fill, reg_q));
         chk("run_shift_R", int'(shift_R), exp_sr(op, fill, reg_q));
         chk("run_busy", int'(busy), 1);
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", lat, exp_lat);
      chk("done_pulse", int'(done), 1);
      chk("done_mode", int'(mode), 0);
      chk("done_busy", int'(busy), 1);
      chk("done_ready", int'(cmd_ready), 0);
      chk("mode_cycles", mcnt, rem_e);
      chk("result_q", int'(reg_q), int'(exp_q));
      chk("parallel_in", int'(parallel_in), int'(data));
      @(posedge clk); #1;
      chk("post_ready", int'(cmd_ready), 1);
      chk("post_done", int'(done), 0);
      chk("post_busy", int'(busy), 0);
   endtask

   typedef struct {
      logic [2:0] op;
      logic [3:0] data;
      logic [2:0] count;
      logic       fill;
      logic [3:0] exp_q;
      int         exp_lat;
   } vec_t;

   vec_t tbl[14];
   logic [3:0] mq;

   initial begin
      tbl[0]  = '{3'd0, 4'b1011, 3'd0, 1'b0, 4'b1011, 2};
      tbl[1]  = '{3'd3, 4'b0000, 3'd1, 1'b0, 4'b0111, 2};
      tbl[2]  = '{3'd4, 4'b0000, 3'd5, 1'b0, 4'b1011, 6};
      tbl[3]  = '{3'd0, 4'b1001, 3'd7, 1'b1, 4'b1001, 2};
      tbl[4]  = '{3'd5, 4'b0000, 3'd2, 1'b0, 4'b1110, 3};
      tbl[5]  = '{3'd1, 4'b0011, 3'd7, 1'b0, 4'b0000, 8};
      tbl[6]  = '{3'd2, 4'b0000, 3'd0, 1'b1, 4'b0000, 1};
      tbl[7]  = '{3'd0, 4'b0110, 3'd0, 1'b0, 4'b0110, 2};
      tbl[8]  = '{3'd6, 4'b1111, 3'd3, 1'b1, 4'b0110, 1};
      tbl[9]  = '{3'd7, 4'b0001, 3'd5, 1'b0, 4'b0110, 1};
      tbl[10] = '{3'd2, 4'b0000, 3'd2, 1'b1, 4'b1101, 3};
      tbl[11] = '{3'd3, 4'b0000, 3'd6, 1'b0, 4'b0111, 7};
      tbl[12] = '{3'd5, 4'b0000, 3'd5, 1'b0, 4'b0000, 6};
      tbl[13] = '{3'd1, 4'b0000, 3'd3, 1'b1, 4'b0111, 4};

      // Reset, with a command presented that must not be accepted.
      rst       = 1'b1;
      cmd_valid = 1'b1;
      cmd_op    = 3'd0;
      cmd_data  = 4'hF;
      cmd_count = 3'd0;
      cmd_fill  = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      chk("rst_ready", int'(cmd_ready), 0);
      chk("rst_mode", int'(mode), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_pin", int'(parallel_in), 0);
      chk("rst_shift_L", int'(shift_L), 0);
      chk("rst_shift_R", int'(shift_R), 0);
      rst       = 1'b0;
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      chk("rel_busy", int'(busy), 0);
      chk("rel_ready", int'(cmd_ready), 1);
      chk("rel_pin", int'(parallel_in), 0);

      foreach (tbl[i])
         run_cmd(tbl[i].op, tbl[i].data, tbl[i].count, tbl[i].fill, tbl[i].exp_q, tbl[i].exp_lat);

      // cmd_valid held through a 3-step SHL with a LOAD queued behind it.
      cmd_valid = 1'b1;
      cmd_op    = 3'd1;
      cmd_data  = 4'b1010;
      cmd_count = 3'd3;
      cmd_fill  = 1'b0;
      @(posedge clk); #1;
      cmd_op    = 3'd0;
      cmd_data  = 4'b0101;
      cmd_count = 3'd0;
      for (int c = 1; c <= 4; c++) begin
         chk("hold_pin", int'(parallel_in), 4'b1010);
         chk("hold_done", int'(done), (c == 4) ? 1 : 0);
         chk("hold_ready", int'(cmd_ready), 0);
         @(posedge clk); #1;
      end
      chk("hold_q", int'(reg_q), 4'b1000);
      chk("hold_ready_back", int'(cmd_ready), 1);
      chk("hold_idle", int'(busy), 0);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      chk("hold2_mode", int'(mode), 3);
      chk("hold2_busy", int'(busy), 1);
      chk("hold2_pin", int'(parallel_in), 4'b0101);
      @(posedge clk); #1;
      chk("hold2_done", int'(done), 1);
      chk("hold2_q", int'(reg_q), 4'b0101);
      @(posedge clk); #1;

      // Reset during a 4-step ROR: one rotation lands, then abort.
      run_cmd(3'd0, 4'b0001, 3'd0, 1'b0, 4'b0001, 2);
      cmd_valid = 1'b1;
      cmd_op    = 3'd4;
      cmd_data  = 4'b0000;
      cmd_count = 3'd4;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      chk("abort_run_mode", int'(mode), 2);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_mode", int'(mode), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         chk("abort_no_done", int'(done), 0);
      end
      chk("abort_q", int'(reg_q), 4'b1000);
      chk("abort_pin", int'(parallel_in), 0);

      // Random commands against the arithmetic model.
      mq = 4'b1000;
      for (int i = 0; i < 60; i++) begin
         logic [2:0] op;
         logic [3:0] data;
         logic [2:0] count;
         logic       fill;
         logic [3:0] nq;
         op    = 3'($urandom_range(0, 7));
         data  = 4'($urandom_range(0, 15));
         count = 3'($urandom_range(0, 7));
         fill  = 1'($urandom_range(0, 1));
         nq    = ref_q(mq, op, data, int'(count), fill);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
         run_cmd(op, data, count, fill, nq, exp_rem(op, count) + 1);
         mq = nq;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
